// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the PS<->PL SPI link (spi_recv and spi_send).
//   - spi_state_e    : frame FSM encoding (IDLE, ACTIVE)
//   - SPI_CPOL/CPHA  : SPI mode 0 constants
//   - SPI_* defaults : default word width, synchronizer depth, counter width
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;
    localparam int SPI_CNT_WIDTH   = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   Multi-flop synchronizer for one asynchronous SPI pin plus registered
//   rise/fall detection.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-high reset (chain loads P_RST_VAL)
//     din   in  asynchronous pin
//     dout  out synchronized level, time-aligned with rise/fall
//     rise  out 1-clk pulse, synchronized 0->1
//     fall  out 1-clk pulse, synchronized 1->0
//   dout is taken from the extra compare flop so that, across instances, a
//   level (e.g. MOSI) is valid in exactly the cycle another instance's edge
//   pulse (e.g. SCLK rise) is asserted.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   P_STAGES  = 2,
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [P_STAGES-1:0] sync_q;
    logic                last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {P_STAGES{P_RST_VAL}};
            last_q <= P_RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[P_STAGES-2:0], din};
            last_q <= sync_q[P_STAGES-1];
            rise   <=  sync_q[P_STAGES-1] & ~last_q;
            fall   <= ~sync_q[P_STAGES-1] &  last_q;
        end
    end

    assign dout = last_q;

endmodule

// File: rtl/spi_recv.sv
// -----------------------------------------------------------------------------
// spi_recv
//   PL-side SPI mode-0 receiver for the PS SPI0 master. Oversamples SCLK, MOSI
//   and SS on clk, shifts MOSI MSB-first on SCLK rising edges and presents each
//   completed word on a valid/ready stream.
//   Ports:
//     clk, rst       system clock, synchronous active-high reset
//     SPI0_SCLK_O    SPI clock from PS (async)
//     SPI0_MOSI_O    SPI data from PS (async)
//     SPI0_SS_O      slave select from PS, active low (async)
//     data_o         received word, stable while valid_o
//     valid_o        word available, held until ready_i
//     ready_i        downstream accept
//     frame_start_o  1-clk pulse on synchronized SS fall
//     frame_end_o    1-clk pulse on synchronized SS rise
//     word_cnt_o     words completed in current/last frame (wraps)
//     abort_o        1-clk pulse when SS rises with a partial word
//     overrun_o      sticky: a word overwrote an unaccepted one; cleared by
//                    rst or frame start
//   SCLK high and low phases must each last >= P_SYNC_STAGES+2 clk periods.
// -----------------------------------------------------------------------------
module spi_recv
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int P_SYNC_STAGES = SPI_SYNC_STAGES,
    parameter int P_CNT_WIDTH   = SPI_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SPI0_SCLK_O,
    input  logic                    SPI0_MOSI_O,
    input  logic                    SPI0_SS_O,
    output logic [P_DATA_WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    frame_start_o,
    output logic                    frame_end_o,
    output logic [P_CNT_WIDTH-1:0]  word_cnt_o,
    output logic                    abort_o,
    output logic                    overrun_o
);

    localparam int BW = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(P_DATA_WIDTH - 1);

    // Synchronized pins. All three chains are identical so MOSI is sampled
    // in the same cycle the SCLK rise is reported.
    logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
    logic ss_rise, ss_fall, ss_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI0_SCLK_O),
        .dout (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    // SS resets high so leaving reset with SS idle produces no edge.
    spi_sync_edge #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI0_SS_O),
        .dout (ss_lvl_unused),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_mosi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI0_MOSI_O),
        .dout (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    spi_state_e              state;
    logic [P_DATA_WIDTH-1:0] sr;
    logic [P_DATA_WIDTH-1:0] sr_nxt;
    logic [BW-1:0]           bit_cnt;
    logic [BW-1:0]           bit_cnt_nxt;
    logic                    shift_en;
    logic                    word_done;

    assign shift_en  = (state == ACTIVE) && sclk_rise;
    assign word_done = shift_en && (bit_cnt == LAST_BIT);
    assign sr_nxt    = {sr[P_DATA_WIDTH-2:0], mosi_s};

    // Bit count after this cycle's SCLK edge; an SS rise in the same cycle
    // judges abort against this value, so a final edge coinciding with SS
    // rise completes the word cleanly.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        if (shift_en)
            bit_cnt_nxt = word_done ? '0 : bit_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sr            <= '0;
            bit_cnt       <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            word_cnt_o    <= '0;
            abort_o       <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            abort_o       <= 1'b0;

            // Output stage: a new word always wins, even against a
            // same-cycle accept; it only counts as overrun if the old word
            // was still pending and not being taken.
            if (word_done) begin
                data_o  <= sr_nxt;
                valid_o <= 1'b1;
                if (valid_o && !ready_i)
                    overrun_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        frame_start_o <= 1'b1;
                        word_cnt_o    <= '0;
                        bit_cnt       <= '0;
                        sr            <= '0;
                        overrun_o     <= 1'b0;
                        state         <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    bit_cnt <= bit_cnt_nxt;
                    if (shift_en)
                        sr <= sr_nxt;
                    if (word_done)
                        word_cnt_o <= word_cnt_o + 1'b1;
                    if (ss_rise) begin
                        frame_end_o <= 1'b1;
                        abort_o     <= (bit_cnt_nxt != '0);
                        bit_cnt     <= '0;
                        sr          <= '0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_recv.sv
// -----------------------------------------------------------------------------
// tb_spi_recv
//   Directed bench for spi_recv: drives SPI mode-0 frames at SCLK = clk/10 and
//   checks received words, frame pulses, abort, overrun and counter wrap
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_recv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       fs;
    logic       fe;
    logic [7:0] wcnt;
    logic       ab;
    logic       ovr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    int n_fs = 0;
    int n_fe = 0;
    int n_ab = 0;

    always #5 clk = ~clk;

    spi_recv #(
        .P_DATA_WIDTH  (8),
        .P_SYNC_STAGES (2),
        .P_CNT_WIDTH   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .SPI0_SCLK_O   (sclk),
        .SPI0_MOSI_O   (mosi),
        .SPI0_SS_O     (ss),
        .data_o        (data),
        .valid_o       (valid),
        .ready_i       (ready),
        .frame_start_o (fs),
        .frame_end_o   (fe),
        .word_cnt_o    (wcnt),
        .abort_o       (ab),
        .overrun_o     (ovr)
    );

    // Monitor on the inactive edge: accepted beats and pulse counts.
    always @(negedge clk) begin
        if (valid && ready) rx_q.push_back(data);
        if (fs) n_fs++;
        if (fe) n_fe++;
        if (ab) n_ab++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        n_fs = 0;
        n_fe = 0;
        n_ab = 0;
    endtask

    // One SPI bit; optionally raise SS together with the SCLK rise.
    task automatic spi_bit(input logic b, input logic ss_with_rise);
        mosi = b;
        tick(5);
        sclk = 1'b1;
        if (ss_with_rise) ss = 1'b1;
        tick(5);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic ss_on_last);
        for (int i = 7; i >= 0; i--)
            spi_bit(v[i], ss_on_last && (i == 0));
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        tick(10);
    endtask

    task automatic frame_close();
        tick(10);
        ss = 1'b1;
        tick(20);
    endtask

    initial begin
        int errs;

        // Reset state
        tick(5);
        chk("rst_data",    32'(data),  32'h0);
        chk("rst_valid",   32'(valid), 32'h0);
        chk("rst_wcnt",    32'(wcnt),  32'h0);
        chk("rst_ovr",     32'(ovr),   32'h0);
        chk("rst_pulses",  32'({fs, fe, ab}), 32'h0);
        rst = 1'b0;
        ready = 1'b1;
        tick(10);
        chk("post_rst_fs", 32'(n_fs), 32'h0);
        clear_mon();

        // Two words, ready held high
        frame_begin();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        frame_close();
        chk("t1_count",  32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("t1_w0", 32'(rx_q[0]), 32'hA5);
            chk("t1_w1", 32'(rx_q[1]), 32'h3C);
        end
        chk("t1_wcnt",   32'(wcnt),  32'd2);
        chk("t1_fs",     32'(n_fs),  32'd1);
        chk("t1_fe",     32'(n_fe),  32'd1);
        chk("t1_abort",  32'(n_ab),  32'd0);
        chk("t1_ovr",    32'(ovr),   32'h0);
        chk("t1_valid",  32'(valid), 32'h0);

        // Overrun: ready low, second word overwrites the first
        clear_mon();
        ready = 1'b0;
        frame_begin();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        frame_close();
        chk("t2_data",   32'(data),  32'h22);
        chk("t2_valid",  32'(valid), 32'h1);
        chk("t2_ovr",    32'(ovr),   32'h1);
        chk("t2_wcnt",   32'(wcnt),  32'd2);
        frame_begin();
        chk("t2_ovr_clr",   32'(ovr),   32'h0);
        chk("t2_valid_hold", 32'(valid), 32'h1);
        ready = 1'b1;
        tick(3);
        chk("t2_valid_drop", 32'(valid), 32'h0);
        chk("t2_acc_count",  32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1)
            chk("t2_acc_data", 32'(rx_q[0]), 32'h22);
        frame_close();
        chk("t2_empty_no_abort", 32'(n_ab), 32'd0);

        // Partial word abort, then a clean frame
        clear_mon();
        frame_begin();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0);
        frame_close();
        chk("t3_abort",  32'(n_ab),  32'd1);
        chk("t3_novalid", 32'(rx_q.size()), 32'd0);
        chk("t3_valid",  32'(valid), 32'h0);
        chk("t3_wcnt",   32'(wcnt),  32'd0);
        frame_begin();
        send_byte(8'h81, 1'b0);
        frame_close();
        chk("t3_count",  32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1)
            chk("t3_data", 32'(rx_q[0]), 32'h81);
        chk("t3_wcnt2",  32'(wcnt),  32'd1);
        chk("t3_abort2", 32'(n_ab),  32'd1);

        // SCLK while deselected is ignored
        clear_mon();
        for (int i = 0; i < 8; i++) spi_bit(1'b1, 1'b0);
        tick(20);
        chk("t4_novalid", 32'(rx_q.size()), 32'd0);
        chk("t4_valid",   32'(valid), 32'h0);
        chk("t4_wcnt",    32'(wcnt),  32'd1);
        chk("t4_pulses",  32'(n_fs + n_fe + n_ab), 32'd0);

        // Reset mid-frame
        clear_mon();
        frame_begin();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0);
        rst = 1'b1;
        ss = 1'b1;
        tick(10);
        chk("t5_rst_data",  32'(data),  32'h0);
        chk("t5_rst_wcnt",  32'(wcnt),  32'h0);
        chk("t5_rst_valid", 32'(valid), 32'h0);
        chk("t5_rst_flags", 32'({fs, fe, ab, ovr}), 32'h0);
        rst = 1'b0;
        tick(10);
        clear_mon();
        frame_begin();
        send_byte(8'h5A, 1'b0);
        frame_close();
        chk("t5_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1)
            chk("t5_data", 32'(rx_q[0]), 32'h5A);
        chk("t5_abort", 32'(n_ab), 32'd0);
        chk("t5_fs",    32'(n_fs), 32'd1);

        // SS rises together with the final SCLK edge: word completes
        clear_mon();
        frame_begin();
        send_byte(8'hC3, 1'b1);
        tick(20);
        chk("t6_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1)
            chk("t6_data", 32'(rx_q[0]), 32'hC3);
        chk("t6_abort", 32'(n_ab), 32'd0);
        chk("t6_fe",    32'(n_fe), 32'd1);
        chk("t6_wcnt",  32'(wcnt), 32'd1);

        // 256-byte incrementing frame, counter wraps
        clear_mon();
        frame_begin();
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0);
        frame_close();
        chk("t7_count", 32'(rx_q.size()), 32'd256);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (i >= rx_q.size() || rx_q[i] !== 8'(i)) errs++;
        chk("t7_order", 32'(errs), 32'd0);
        chk("t7_wcnt",  32'(wcnt), 32'h00);
        chk("t7_ovr",   32'(ovr),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
